// File: rtl/prog_loader.sv
// prog_loader: MSB-first serial loader that fills the SAP RAM over the bus.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [7:0]        bus_out,
  output logic              bus_drive,
  output logic              mem_adr_we,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] LP_WORDS = (ADDR_W+1)'(WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ADDR, S_DATA, S_DONE, S_CHECK, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ADDR, S_DATA, S_DONE
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_shift;
  logic [2:0]        r_bcnt;
  logic [7:0]        r_hold;
  logic [ADDR_W:0]   r_wc;
  logic [7:0]        w_byte;
  logic              w_last_bit;
  logic              w_shifting;
  logic [ADDR_W:0]   w_wc_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_acc;
  logic [7:0]        w_sum;
`endif

  assign w_byte     = {r_shift[6:0], bit_in};
  assign w_last_bit = bit_valid && (r_bcnt == 3'd7);
  assign w_wc_inc   = r_wc + (ADDR_W+1)'(1);
  assign word_count = r_wc;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_sum      = r_acc + w_byte;
  assign w_shifting = (r_state == S_SHIFT) || (r_state == S_ADDR) ||
                      (r_state == S_DATA)  || (r_state == S_CHECK);
`else
  assign w_shifting = (r_state == S_SHIFT) || (r_state == S_ADDR) ||
                      (r_state == S_DATA);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (load_en) w_next = S_SHIFT;
      S_SHIFT: begin
        if (!load_en)        w_next = S_IDLE;
        else if (w_last_bit) w_next = S_ADDR;
      end
      S_ADDR:  w_next = load_en ? S_DATA : S_IDLE;
      S_DATA: begin
        if (!load_en)
          w_next = S_IDLE;
        else if (w_wc_inc == LP_WORDS)
`ifdef PROG_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        else
          w_next = S_SHIFT;
      end
      S_DONE:  if (!load_en) w_next = S_IDLE;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (!load_en)        w_next = S_IDLE;
        else if (w_last_bit) w_next = (w_sum == 8'h00) ? S_DONE : S_ERROR;
      end
      S_ERROR: if (!load_en) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_out    = 8'h00;
    bus_drive  = 1'b0;
    mem_adr_we = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (r_state)
      S_SHIFT: cpu_hold = 1'b1;
      S_ADDR: begin
        cpu_hold   = 1'b1;
        bus_drive  = 1'b1;
        mem_adr_we = 1'b1;
        bus_out    = 8'(r_wc[ADDR_W-1:0]);
      end
      S_DATA: begin
        cpu_hold  = 1'b1;
        bus_drive = 1'b1;
        mem_we    = 1'b1;
        bus_out   = r_hold;
      end
      S_DONE:  done = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: cpu_hold = 1'b1;
      S_ERROR: begin
        cpu_hold = 1'b1;
        error    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= 8'h00;
      r_bcnt  <= 3'd0;
      r_hold  <= 8'h00;
      r_wc    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_acc   <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && load_en) begin
        r_bcnt <= 3'd0;
        r_wc   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_acc  <= 8'h00;
`endif
      end
      // shift register runs through ADDR/DATA; hold keeps the byte stable
      if (w_shifting && bit_valid) begin
        r_shift <= w_byte;
        r_bcnt  <= r_bcnt + 3'd1;
      end
      if (r_state == S_SHIFT && w_last_bit)
        r_hold <= w_byte;
      if (r_state == S_DATA) begin
        r_wc  <= w_wc_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_acc <= r_acc + r_hold;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a bus-side RAM model.
// Checksum cases are compiled in when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic       mem_adr_we;
  logic       mem_we;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [4:0] word_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_wr     = 0;

  logic       mon_en  = 1'b0;
  logic       ram_clr = 1'b0;
  logic [3:0] m_mar;
  logic [7:0] m_ram [16];
  logic [7:0] stim  [16];

  always #5 clk = ~clk;

  prog_loader #(.WORDS(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bus_out    (bus_out),
    .bus_drive  (bus_drive),
    .mem_adr_we (mem_adr_we),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // machine side: MAR then RAM, both latched on the rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) m_ram[i] <= 8'hCC;
    end else begin
      if (mem_adr_we) m_mar <= bus_out[3:0];
      if (mem_we) begin
        m_ram[m_mar] <= bus_out;
        n_wr <= n_wr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_excl", 32'(mem_we & mem_adr_we), 0);
      chk("drv_strobe", 32'(bus_drive), 32'(mem_we | mem_adr_we));
`ifndef PROG_LOADER_CHECKSUM_EN
      chk("err_tied", 32'(error), 0);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus"}, 32'(bus_out), 0);
    chk({tag, "_drv"}, 32'(bus_drive), 0);
    chk({tag, "_awe"}, 32'(mem_adr_we), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_hold"}, 32'(cpu_hold), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
    chk({tag, "_wc"}, 32'(word_count), 0);
  endtask

  task automatic ram_clear();
    ram_clr = 1'b1;
    step();
    ram_clr = 1'b0;
  endtask

  task automatic start_session();
    chk("hold_pre", 32'(cpu_hold), 0);
    load_en = 1'b1;
    step();
    chk("hold_rise", 32'(cpu_hold), 1);
  endtask

  // leaves bit_valid high so consecutive calls stream without gaps
  task automatic send_bits(input logic [7:0] b, input int nbits,
                           input int maxgap);
    for (int i = 7; i > 7 - nbits; i--) begin
      int g;
      g = $urandom_range(maxgap, 0);
      repeat (g) begin
        bit_valid = 1'b0;
        step();
      end
      bit_in    = b[i];
      bit_valid = 1'b1;
      step();
    end
  endtask

  task automatic full_load(input int maxgap, input logic [7:0] ck,
                           input logic time_it);
    int   t0;
    int   n;
    int   s;
    logic ok;
    ram_clear();
    start_session();
    t0 = cyc;
    for (int i = 0; i < 16; i++) send_bits(stim[i], 8, maxgap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_bits(ck, 8, maxgap);
`endif
    bit_valid = 1'b0;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 64) begin
      step();
      n++;
    end
    chk("fin_timeout", 32'(done | error), 1);
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(stim[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    ok = (8'(s + int'(ck)) == 8'h00);
`else
    ok = 1'b1;
`endif
    chk("fin_done", 32'(done), 32'(ok));
    chk("fin_err", 32'(error), 32'(!ok));
    chk("fin_hold", 32'(cpu_hold), 32'(!ok));
`ifndef PROG_LOADER_CHECKSUM_EN
    if (time_it) chk("done_lat", 32'(cyc - t0), 130);
`endif
    chk("fin_wc", 32'(word_count), 16);
    for (int i = 0; i < 16; i++) chk("ram", 32'(m_ram[i]), 32'(stim[i]));
    repeat (3) step();
    chk("stay_done", 32'(done), 32'(ok));
    chk("stay_hold", 32'(cpu_hold), 32'(!ok));
    load_en = 1'b0;
    step();
    chk("rel_done", 32'(done), 0);
    chk("rel_hold", 32'(cpu_hold), 0);
    chk("rel_err", 32'(error), 0);
  endtask

  function automatic logic [7:0] good_ck();
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(stim[i]);
    return 8'(256 - (s % 256));
  endfunction

  initial begin
    logic [7:0] b;
    logic [7:0] ck;
    int         n0;
    reset     = 1'b1;
    load_en   = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) step();
    chk_zero("rst");
    reset  = 1'b0;
    mon_en = 1'b1;
    step();
    chk_zero("idle");

    // single byte: ADDR then DATA strobes
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      ram_clear();
      start_session();
      send_bits(b, 8, t);
      bit_valid = 1'b0;
      chk("sb_addr_bus", 32'(bus_out), 0);
      chk("sb_addr_awe", 32'(mem_adr_we), 1);
      chk("sb_addr_we", 32'(mem_we), 0);
      step();
      chk("sb_data_bus", 32'(bus_out), 32'(b));
      chk("sb_data_we", 32'(mem_we), 1);
      chk("sb_data_awe", 32'(mem_adr_we), 0);
      step();
      chk("sb_wc", 32'(word_count), 1);
      chk("sb_hold", 32'(cpu_hold), 1);
      chk("sb_ram0", 32'(m_ram[0]), 32'(b));
      load_en = 1'b0;
      step();
      chk("sb_abort_hold", 32'(cpu_hold), 0);
      chk("sb_abort_done", 32'(done), 0);
    end

    // reset mid-session after one written byte plus 5 bits
    start_session();
    send_bits(8'($urandom), 8, 0);
    send_bits(8'($urandom), 5, 0);
    bit_valid = 1'b0;
    chk("rm_wc", 32'(word_count), 1);
    reset = 1'b1;
    n0 = n_wr;
    step();
    chk_zero("rm_in");
    reset   = 1'b0;
    load_en = 1'b0;
    step();
    chk_zero("rm_after");
    chk("rm_nowr", 32'(n_wr - n0), 0);

    // full timed load 0x01..0x10 with continuous bits
    for (int i = 0; i < 16; i++) stim[i] = 8'(i + 1);
    full_load(0, 8'h78, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    full_load(0, 8'h77, 1'b0);
`endif

    // randomized loads with idle gaps between bits
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
      ck = good_ck();
      if (t[0]) ck = ck + 8'($urandom_range(255, 1));
      full_load(t, ck, 1'b0);
    end

    // abort after 3 of 16 bytes, mid-way through the 4th
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    ram_clear();
    n0 = n_wr;
    start_session();
    for (int i = 0; i < 3; i++) send_bits(stim[i], 8, 2);
    send_bits(stim[3], 4, 1);
    bit_valid = 1'b0;
    chk("ab_wc", 32'(word_count), 3);
    load_en = 1'b0;
    step();
    chk("ab_hold", 32'(cpu_hold), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_drv", 32'(bus_drive), 0);
    repeat (2) step();
    chk("ab_nwr", 32'(n_wr - n0), 3);
    for (int i = 0; i < 3; i++) chk("ab_ram", 32'(m_ram[i]), 32'(stim[i]));
    chk("ab_ram3", 32'(m_ram[3]), 32'hCC);
    chk("ab_idle_done", 32'(done), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that fills the SAP machine's 16-byte RAM from outside the chip before execution. It deserialises an MSB-first bit stream into bytes and writes each byte into RAM through the shared bus. Each write is a memory-address-register write followed by a memory write. While loading, it holds the CPU in reset, and it releases the CPU once every word has been written. It sits between the chip input pins and the machine's bus, external-drive and memory write-enable controls.

## Interface
Parameters:
- `WORDS`, default 16: number of RAM words loaded per session.
- `ADDR_W`, default 4: address width; `WORDS` ≤ 2^`ADDR_W`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_en`  in  1  level; high requests and sustains a load session; low aborts.
- `bit_in`  in  1  serial data bit, sampled when `bit_valid` = 1.
- `bit_valid`  in  1  one-cycle qualifier, at most one per clock, already synchronous to `clk`.
- `bus_out`  out  8  value to drive onto the machine bus.
- `bus_drive`  out  1  bus select for `bus_out`; outranks every internal bus source.
- `mem_adr_we`  out  1  write enable for the memory address register.
- `mem_we`  out  1  write enable for the RAM data word.
- `cpu_hold`  out  1  ORed into the CPU's reset; high for the whole session.
- `done`  out  1  high after a complete, accepted load.
- `error`  out  1  checksum failure; constant 0 without the macro.
- `word_count`  out  `ADDR_W`+1  bytes written so far in the current session.

## Operation
- FSM states: IDLE, SHIFT, ADDR, DATA, DONE, plus CHECK and ERROR with the macro.
- Reset values:
  - state = IDLE.
  - All outputs are 0, including `bus_out` = 0x00.
  - Shift register, bit counter (3 bits), `word_count` and checksum accumulator are all 0.
- IDLE: when `load_en` = 1, go to SHIFT and clear the bit counter, `word_count` and accumulator.
- SHIFT:
  - On each `bit_valid`: `shift <= {shift[6:0], bit_in}` and the bit counter increments.
  - On the 8th bit, the completed byte is copied to a holding register and the FSM goes to ADDR. The bit counter wraps to 0.
- ADDR:
  - `bus_drive` = 1, `mem_adr_we` = 1, `bus_out` = {zero-pad, `word_count[ADDR_W-1:0]`}.
  - Next state is DATA.
- DATA:
  - `bus_drive` = 1, `mem_we` = 1, `bus_out` = holding register.
  - `word_count` increments.
  - Next state is DONE if the incremented count equals `WORDS` (or CHECK with the macro); otherwise SHIFT.
- Shifting continues during ADDR and DATA, because the shift register is independent of the holding register.
  - A `bit_valid` in those cycles is captured.
  - A byte cannot complete before DATA ends, since a byte takes at least 8 cycles, so overrun is impossible.
- DONE: `done` = 1 and `cpu_hold` = 0. It stays in DONE until `load_en` = 0, then goes to IDLE and `done` drops.
- `cpu_hold` = 1 in SHIFT, ADDR, DATA, CHECK and ERROR.
- `bus_drive`, `mem_adr_we` and `mem_we` are never high outside ADDR or DATA, and never both write enables in the same cycle.
- Abort: `load_en` = 0 in SHIFT, ADDR or DATA returns the FSM to IDLE on the next edge.
  - `cpu_hold` drops.
  - RAM words already written remain; a partial byte is discarded.
  - `done` stays 0.
- `reset` at any time forces the reset values on the next edge and overrides `load_en`. RAM contents are unaffected.

## Timing
- All outputs are decoded from registered state or registers; there are no input-to-output combinational paths.
- `cpu_hold` rises in the cycle after `load_en` is first sampled high.
- If the 8th bit of a byte is sampled at edge N:
  - ADDR outputs are valid during cycle N..N+1, and RAM latches the address at edge N+1.
  - DATA outputs are valid during N+1..N+2, and RAM latches the data at edge N+2.
- After the last DATA cycle, `done` = 1 and `cpu_hold` = 0 from the next cycle, so the CPU starts 1 cycle later.
- Minimum session: 8·`WORDS` + 2 cycles at continuous `bit_valid`.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last DATA cycle the FSM enters CHECK and receives one more byte in CHECK; it is not written to RAM.
  - Acceptance rule: (sum of all `WORDS` data bytes + checksum byte) mod 256 = 0x00.
  - On acceptance the next state is DONE.
  - Otherwise the next state is ERROR: `error` = 1 and `cpu_hold` stays 1 until `load_en` = 0, then IDLE.
  - The accumulator is 8 bits wide and wraps.
- Undefined: no CHECK or ERROR state, `error` tied 0, DONE follows the last DATA cycle directly.

## Test plan
- Reset mid-session: raise `load_en`, shift 5 bits, assert `reset` for 1 cycle → all outputs 0, state IDLE on the next cycle, no write strobes.
- Single byte: `load_en` = 1, shift 0xA5 MSB first → ADDR cycle with `bus_out` = 0x00 and `mem_adr_we` = 1, then DATA cycle with `bus_out` = 0xA5 and `mem_we` = 1; `word_count` = 1.
- Full load: shift bytes 0x01..0x10 with continuous `bit_valid` →
  - RAM[i] = i+1;
  - `done` rises exactly 130 cycles after the first bit is sampled;
  - `cpu_hold` falls in the same cycle.
- Back-to-back bits across writes: keep `bit_valid` high during ADDR and DATA → no bit is lost; the second byte equals the stimulus.
- Abort: drop `load_en` after 3 of 16 bytes → IDLE next cycle, `cpu_hold` = 0, `done` = 0, RAM[0..2] written, RAM[3] untouched.
- Checksum (macro defined): bytes 0x01..0x10 plus 0x78 → `done` = 1. Same bytes plus 0x77 → `error` = 1 and `cpu_hold` stays 1.
